scroll_marquee: RTL and testbench

Parametrised scrolling-text engine for the seven-segment display path. It holds a DIGITS-digit string of DW-bit codes and steps it one digit at a time. Step modes are rotate, bounce (ping-pong), one-shot and hold, and the step rate comes from an internal programmable divider. It exports the full string, a WIN-digit visible window and the scroll position, and sits between the text source and the display scanner.

---
 rtl/scroll_marquee.sv | 192 +++++++++++++++++++
 tb/tb_scroll_marquee.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_marquee.sv
// ---------------------------------------------------------------------------
// scroll_marquee
//
// Scrolling-text engine for the seven-segment display path. It holds a
// DIGITS-digit string of DW-bit codes and rotates it one digit at a time.
// Steps are paced by an internal programmable divider. The step pattern is
// selected by mode: rotate, bounce (ping-pong inside the visible window
// range), one-shot (a single full revolution), or hold.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset, loads TEXT
//   ld       : synchronous load of text_in (wins over en and mode)
//   text_in  : string captured on ld, leftmost digit in the MSBs
//   en       : run enable, freezes divider and step state when low
//   dir      : rotate / one-shot direction, 0 = left, 1 = right
//   mode     : 00 rotate, 01 bounce, 10 one-shot, 11 hold
//   div      : step period in clocks, 0 behaves as 1
//   q        : current string
//   win      : leftmost WIN digits of q
//   pos      : net left steps modulo DIGITS
//   wrap     : one-cycle pulse after a step that lands pos on 0
//   busy     : low once one-shot mode has completed its revolution
// ---------------------------------------------------------------------------
module scroll_marquee #(
    parameter int                   DIGITS = 13,
    parameter int                   DW     = 4,
    parameter int                   WIN    = 8,
    parameter int                   DIV_W  = 24,
    parameter logic [DIGITS*DW-1:0] TEXT   = 52'haaa9876543210,
    localparam int                  PW     = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld,
    input  logic [DIGITS*DW-1:0]   text_in,
    input  logic                   en,
    input  logic                   dir,
    input  logic [1:0]             mode,
    input  logic [DIV_W-1:0]       div,
    output logic [DIGITS*DW-1:0]   q,
    output logic [WIN*DW-1:0]      win,
    output logic [PW-1:0]          pos,
    output logic                   wrap,
    output logic                   busy
);

    localparam int N = DIGITS * DW;

    // Highest pos value; stepping past it wraps back to 0.
    localparam logic [PW-1:0] LAST_POS = PW'(DIGITS - 1);

    // Once a left-going bounce reaches this offset the window's right edge
    // sits on the last digit of the string, so the bounce turns around.
    localparam logic [PW-1:0] TURN_POS = PW'(DIGITS - WIN);

    // With the window as wide as the string there is nothing to bounce over.
    localparam bit CAN_BOUNCE = (WIN < DIGITS);

    typedef enum logic [1:0] {
        MODE_ROTATE  = 2'b00,
        MODE_BOUNCE  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic {
        BOUNCE_LEFT  = 1'b0,
        BOUNCE_RIGHT = 1'b1
    } bounce_dir_e;

    mode_e              mode_sel;
    bounce_dir_e        bdir;
    bounce_dir_e        bdir_next;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   cnt_next;
    logic [DIV_W-1:0]   period;
    logic               active;
    logic               tick;
    logic               step_left;
    logic               step_right;
    logic               done;
    logic               done_next;
    logic [PW-1:0]      pos_next;
    logic [N-1:0]       q_next;
    logic               wrap_next;

    assign mode_sel = mode_e'(mode);

    // Divider: cnt counts enabled cycles up to period-1. The >= compare
    // means a div shrunk below the running count fires on the next
    // enabled cycle instead of waiting for the counter to wrap.
    always_comb begin
        period   = (div == '0) ? DIV_W'(1) : div;
        active   = en && (mode_sel != MODE_HOLD);
        tick     = active && (cnt >= (period - DIV_W'(1)));
        cnt_next = cnt;
        if (tick) begin
            cnt_next = '0;
        end else if (active) begin
            cnt_next = cnt + DIV_W'(1);
        end
    end

    // Step decision. Direction and mode are only consulted on a tick, so a
    // change to either takes effect at the next tick.
    always_comb begin
        step_left  = 1'b0;
        step_right = 1'b0;
        bdir_next  = bdir;
        if (tick) begin
            case (mode_sel)
                MODE_ROTATE: begin
                    step_right = dir;
                    step_left  = !dir;
                end
                MODE_BOUNCE: begin
                    if (CAN_BOUNCE) begin
                        if ((bdir == BOUNCE_LEFT) && (pos >= TURN_POS)) begin
                            bdir_next  = BOUNCE_RIGHT;
                            step_right = 1'b1;
                        end else if ((bdir == BOUNCE_RIGHT) && (pos == '0)) begin
                            bdir_next  = BOUNCE_LEFT;
                            step_left  = 1'b1;
                        end else begin
                            step_right = (bdir == BOUNCE_RIGHT);
                            step_left  = (bdir == BOUNCE_LEFT);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (!done) begin
                        step_right = dir;
                        step_left  = !dir;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Apply the chosen step to the string and offset. A step that lands on
    // offset 0 raises wrap and, in one-shot mode, ends the revolution.
    always_comb begin
        q_next    = q;
        pos_next  = pos;
        done_next = done;
        if (step_left) begin
            q_next   = {q[N-DW-1:0], q[N-1:N-DW]};
            pos_next = (pos == LAST_POS) ? '0 : pos + PW'(1);
        end else if (step_right) begin
            q_next   = {q[DW-1:0], q[N-1:DW]};
            pos_next = (pos == '0) ? LAST_POS : pos - PW'(1);
        end
        wrap_next = (step_left || step_right) && (pos_next == '0);
        if ((mode_sel == MODE_ONESHOT) && wrap_next) begin
            done_next = 1'b1;
        end
    end

    // State register. Load restarts the divider and the step state but
    // never produces a wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= TEXT;
            pos  <= '0;
            cnt  <= '0;
            bdir <= BOUNCE_LEFT;
            done <= 1'b0;
            wrap <= 1'b0;
        end else if (ld) begin
            q    <= text_in;
            pos  <= '0;
            cnt  <= '0;
            bdir <= BOUNCE_LEFT;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            pos  <= pos_next;
            cnt  <= cnt_next;
            bdir <= bdir_next;
            done <= done_next;
            wrap <= wrap_next;
        end
    end

    assign win  = q[N-1 -: WIN*DW];
    assign busy = !done;

endmodule

// File: tb/tb_scroll_marquee.sv
// ---------------------------------------------------------------------------
// tb_scroll_marquee
//
// Self-checking bench for scroll_marquee with default parameters. A
// reference model keeps the loaded string plus an integer offset and
// derives the expected display as that string rotated left by the offset.
// Directed phases cover reset, rotate, divider pause, bounce, one-shot,
// load priority and asynchronous reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_scroll_marquee;

    localparam int DIGITS = 13;
    localparam int DW     = 4;
    localparam int WIN    = 8;
    localparam int DIV_W  = 24;
    localparam int N      = DIGITS * DW;
    localparam int PW     = 4;
    localparam logic [N-1:0] TEXT = 52'haaa9876543210;

    logic               clk;
    logic               rst_n;
    logic               ld;
    logic [N-1:0]       text_in;
    logic               en;
    logic               dir;
    logic [1:0]         mode;
    logic [DIV_W-1:0]   div;
    logic [N-1:0]       q;
    logic [WIN*DW-1:0]  win;
    logic [PW-1:0]      pos;
    logic               wrap;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: the string as last loaded, and the scroll
    // offset, divider count, bounce direction, one-shot flag and wrap.
    logic [DW-1:0] m_base [DIGITS];
    int            m_pos;
    int            m_cnt;
    int            m_bdir;
    int            m_done;
    int            m_wrap;

    scroll_marquee #(
        .DIGITS (DIGITS),
        .DW     (DW),
        .WIN    (WIN),
        .DIV_W  (DIV_W),
        .TEXT   (TEXT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld),
        .text_in (text_in),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .div     (div),
        .q       (q),
        .win     (win),
        .pos     (pos),
        .wrap    (wrap),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelLoad(input logic [N-1:0] text);
        for (int i = 0; i < DIGITS; i++) begin
            m_base[i] = text[N-1-i*DW -: DW];
        end
        m_pos  = 0;
        m_cnt  = 0;
        m_bdir = 0;
        m_done = 0;
        m_wrap = 0;
    endtask

    // Expected string: digit i (0 = leftmost) is base digit (i+pos) mod DIGITS.
    function automatic logic [N-1:0] modelQ();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[N-1-i*DW -: DW] = m_base[(i + m_pos) % DIGITS];
        end
        return r;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic modelStep();
        int p;
        int step;
        if (ld) begin
            modelLoad(text_in);
            return;
        end
        p    = (div == 0) ? 1 : int'(div);
        step = 0;
        if (en && mode != 2'b11) begin
            if (m_cnt >= p - 1) begin
                m_cnt = 0;
                case (mode)
                    2'b00: step = dir ? -1 : 1;
                    2'b01: begin
                        if (WIN < DIGITS) begin
                            if (m_bdir == 0 && m_pos >= DIGITS - WIN) begin
                                m_bdir = 1;
                                step   = -1;
                            end else if (m_bdir == 1 && m_pos == 0) begin
                                m_bdir = 0;
                                step   = 1;
                            end else begin
                                step = m_bdir ? -1 : 1;
                            end
                        end
                    end
                    2'b10: if (m_done == 0) step = dir ? -1 : 1;
                    default: ;
                endcase
            end else begin
                m_cnt++;
            end
        end
        m_pos  = (m_pos + step + DIGITS) % DIGITS;
        m_wrap = (step != 0 && m_pos == 0) ? 1 : 0;
        if (mode == 2'b10 && m_wrap == 1) m_done = 1;
    endtask

    task automatic compareModel();
        logic [N-1:0] eq;
        eq = modelQ();
        checkOutput("q", 64'(q), 64'(eq));
        checkOutput("win", 64'(win), 64'(eq[N-1 -: WIN*DW]));
        checkOutput("pos", 64'(pos), 64'(m_pos));
        checkOutput("wrap", 64'(wrap), 64'(m_wrap));
        checkOutput("busy", 64'(busy), 64'(m_done == 0));
    endtask

    // One clock: update the model, take the edge, sample 1ns later.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        compareModel();
    endtask

    task automatic loadText(input logic [N-1:0] text);
        ld      = 1'b1;
        text_in = text;
        applyStimulus();
        ld      = 1'b0;
    endtask

    initial begin
        int wraps;
        int bounce_seq [12];
        logic [63:0] rnd;

        rst_n   = 1'b0;
        ld      = 1'b0;
        en      = 1'b0;
        dir     = 1'b0;
        mode    = 2'b00;
        div     = DIV_W'(1);
        text_in = '0;
        modelLoad(TEXT);

        // Reset state
        #12;
        checkOutput("reset_q", 64'(q), 64'(52'haaa9876543210));
        checkOutput("reset_win", 64'(win), 64'(32'haaa98765));
        checkOutput("reset_pos", 64'(pos), 64'd0);
        checkOutput("reset_wrap", 64'(wrap), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b1;

        // Rotate left at full rate
        mode = 2'b00;
        dir  = 1'b0;
        div  = DIV_W'(1);
        en   = 1'b1;
        applyStimulus();
        checkOutput("rotl_first_q", 64'(q), 64'(52'haa9876543210a));
        checkOutput("rotl_first_pos", 64'(pos), 64'd1);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (wrap) wraps++;
        end
        checkOutput("rotl_full_q", 64'(q), 64'(TEXT));
        checkOutput("rotl_wrap_count", 64'(wraps), 64'd1);
        en = 1'b0;

        // Rotate right with divider and pause
        dir = 1'b1;
        div = DIV_W'(3);
        loadText(TEXT);
        en = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rotr_no_early_step", 64'(pos), 64'd0);
        applyStimulus();
        checkOutput("rotr_first_q", 64'(q), 64'(52'h0aaa987654321));
        checkOutput("rotr_first_pos", 64'(pos), 64'd12);
        applyStimulus();
        en = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("pause_pos", 64'(pos), 64'd12);
        en = 1'b1;
        applyStimulus();
        checkOutput("resume_hold_pos", 64'(pos), 64'd12);
        applyStimulus();
        checkOutput("resume_step_pos", 64'(pos), 64'd11);
        en = 1'b0;

        // Bounce
        mode = 2'b01;
        div  = DIV_W'(1);
        loadText(TEXT);
        en = 1'b1;
        bounce_seq = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            checkOutput("bounce_pos", 64'(pos), 64'(bounce_seq[i]));
            if (i == 9) checkOutput("bounce_wrap", 64'(wrap), 64'd1);
        end
        en = 1'b0;

        // One-shot and reload
        mode = 2'b10;
        dir  = 1'b0;
        div  = DIV_W'(2);
        loadText(TEXT);
        en = 1'b1;
        for (int i = 0; i < 26; i++) applyStimulus();
        checkOutput("oneshot_q", 64'(q), 64'(TEXT));
        checkOutput("oneshot_wrap", 64'(wrap), 64'd1);
        checkOutput("oneshot_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 20; i++) applyStimulus();
        checkOutput("oneshot_frozen_q", 64'(q), 64'(TEXT));
        checkOutput("oneshot_frozen_busy", 64'(busy), 64'd0);
        loadText(52'h0123456789abc);
        checkOutput("reload_q", 64'(q), 64'(52'h0123456789abc));
        checkOutput("reload_pos", 64'(pos), 64'd0);
        checkOutput("reload_busy", 64'(busy), 64'd1);
        applyStimulus();
        applyStimulus();
        checkOutput("reload_step_q", 64'(q), 64'(52'h123456789abc0));

        // Load wins over a tick in the same cycle
        mode = 2'b00;
        div  = DIV_W'(1);
        loadText(52'hfedcba9876543);
        checkOutput("prio_q", 64'(q), 64'(52'hfedcba9876543));
        checkOutput("prio_pos", 64'(pos), 64'd0);

        // Asynchronous reset mid-count
        div = DIV_W'(5);
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("precount_pos", 64'(pos), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_q", 64'(q), 64'(TEXT));
        checkOutput("async_pos", 64'(pos), 64'd0);
        checkOutput("async_wrap", 64'(wrap), 64'd0);
        checkOutput("async_busy", 64'(busy), 64'd1);
        modelLoad(TEXT);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("post_reset_wait_pos", 64'(pos), 64'd0);
        applyStimulus();
        checkOutput("post_reset_step_pos", 64'(pos), 64'd1);

        // Randomized phase against the model
        for (int i = 0; i < 800; i++) begin
            rnd     = {$urandom(), $urandom()};
            ld      = ($urandom_range(0, 29) == 0);
            text_in = rnd[N-1:0];
            en      = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) div = DIV_W'($urandom_range(0, 4));
            applyStimulus();
        end
        ld = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
